// File: rtl/ip_tile_arb_pkg.sv
// Shared types and default widths for the two-requester tile arbiter.
package ip_tile_arb_pkg;

    localparam int CSR_IN_W_DEF  = 16;
    localparam int CSR_OUT_W_DEF = 16;
    localparam int REG_W_DEF     = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/ip_tile_rr_arb2.sv
// Two-way round-robin grant with a last-served pointer that moves only on acceptance.
module ip_tile_rr_arb2 (
    input  logic       clk,
    input  logic       arst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_q;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    // Pointer resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= grant[1];
        end
    end

endmodule

// File: rtl/ip_tile_arbiter.sv
// Arbitrates two requesters onto one compute tile and returns the tile's status/result.
// Optional watchdog enabled by defining IP_TILE_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a request, req_ready follows the round-robin grant
// ISSUE | command on csr_in until the tile consumes it
// WAIT  | command consumed, waiting for the tile's status strobe
// RESP  | response held on resp_* until resp_ready
module ip_tile_arbiter
    import ip_tile_arb_pkg::*;
#(
    parameter int CSR_IN_WIDTH   = CSR_IN_W_DEF,
    parameter int CSR_OUT_WIDTH  = CSR_OUT_W_DEF,
    parameter int REG_WIDTH      = REG_W_DEF,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic [1:0]                   req_valid,
    output logic [1:0]                   req_ready,
    input  logic [1:0][CSR_IN_WIDTH-1:0] req_csr,
    input  logic [1:0][REG_WIDTH-1:0]    req_a,
    input  logic [1:0][REG_WIDTH-1:0]    req_b,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic                         resp_id,
    output logic [CSR_OUT_WIDTH-1:0]     resp_csr,
    output logic [REG_WIDTH-1:0]         resp_data,
    output logic                         resp_err,
    output logic [CSR_IN_WIDTH-1:0]      csr_in,
    input  logic                         csr_in_re,
    output logic [REG_WIDTH-1:0]         data_reg_a,
    output logic [REG_WIDTH-1:0]         data_reg_b,
    input  logic [CSR_OUT_WIDTH-1:0]     csr_out,
    input  logic                         csr_out_we,
    input  logic [REG_WIDTH-1:0]         data_reg_c,
    output logic                         busy
);

    arb_state_e               state_q, state_d;
    logic [1:0]               grant;
    logic                     accept, sel, capture, timeout_hit, timeout_go;
    logic [CSR_IN_WIDTH-1:0]  cmd_q;
    logic [REG_WIDTH-1:0]     a_q, b_q, resp_data_q;
    logic [CSR_OUT_WIDTH-1:0] resp_csr_q;
    logic                     id_q;

    ip_tile_rr_arb2 u_rr (
        .clk    (clk),
        .arst_n (arst_n),
        .req    (req_valid),
        .accept (accept),
        .grant  (grant)
    );

    // Gated by arst_n so the combinational ready is also zero during reset.
    assign req_ready = (arst_n && state_q == IDLE) ? grant : 2'b00;
    assign accept    = |req_ready;
    assign sel       = req_ready[1];

    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        timeout_go = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = ISSUE;
            end
            ISSUE: begin
                if (csr_in_re && csr_out_we) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    timeout_go = 1'b1;
                    state_d    = RESP;
                end else if (csr_in_re) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (csr_out_we) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    timeout_go = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cmd_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            resp_csr_q  <= '0;
            resp_data_q <= '0;
        end else begin
            if (accept) begin
                cmd_q <= req_csr[sel];
                a_q   <= req_a[sel];
                b_q   <= req_b[sel];
                id_q  <= sel;
            end
            if (capture) begin
                resp_csr_q  <= csr_out;
                resp_data_q <= data_reg_c;
            end else if (timeout_go) begin
                resp_csr_q  <= '0;
                resp_data_q <= '0;
            end
        end
    end

`ifdef IP_TILE_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             resp_err_q;

    // Down-counter loaded on acceptance; terminal count on the last allowed ISSUE/WAIT cycle.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            tmo_cnt_q <= '0;
        end else if (accept) begin
            tmo_cnt_q <= CNT_W'(TIMEOUT_CYCLES - 1);
        end else if ((state_q == ISSUE || state_q == WAIT) && tmo_cnt_q != '0) begin
            tmo_cnt_q <= tmo_cnt_q - 1'b1;
        end
    end

    assign timeout_hit = (tmo_cnt_q == '0);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            resp_err_q <= 1'b0;
        end else if (capture || timeout_go) begin
            resp_err_q <= timeout_go;
        end
    end

    assign resp_err = resp_err_q;
`else
    assign timeout_hit = 1'b0;
    assign resp_err    = 1'b0;
`endif

    assign resp_valid = (state_q == RESP);
    assign resp_id    = id_q;
    assign resp_csr   = resp_csr_q;
    assign resp_data  = resp_data_q;
    assign csr_in     = (state_q == ISSUE) ? cmd_q : '0;
    assign data_reg_a = a_q;
    assign data_reg_b = b_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ip_tile_arbiter.sv
// Self-checking bench for ip_tile_arbiter: vector table plus reset/timeout sequences.
module tb_ip_tile_arbiter;

    localparam int TMO = 16;

    logic              clk = 1'b0;
    logic              arst_n = 1'b0;
    logic [1:0]        req_valid = '0;
    logic [1:0]        req_ready;
    logic [1:0][15:0]  req_csr = '0;
    logic [1:0][31:0]  req_a = '0;
    logic [1:0][31:0]  req_b = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic              resp_id;
    logic [15:0]       resp_csr;
    logic [31:0]       resp_data;
    logic              resp_err;
    logic [15:0]       csr_in;
    logic              csr_in_re = 1'b0;
    logic [31:0]       data_reg_a, data_reg_b;
    logic [15:0]       csr_out = '0;
    logic              csr_out_we = 1'b0;
    logic [31:0]       data_reg_c = '0;
    logic              busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ip_tile_arbiter #(
        .CSR_IN_WIDTH(16), .CSR_OUT_WIDTH(16), .REG_WIDTH(32), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_csr(req_csr), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_csr(resp_csr), .resp_data(resp_data), .resp_err(resp_err),
        .csr_in(csr_in), .csr_in_re(csr_in_re),
        .data_reg_a(data_reg_a), .data_reg_b(data_reg_b),
        .csr_out(csr_out), .csr_out_we(csr_out_we), .data_reg_c(data_reg_c),
        .busy(busy)
    );

    typedef struct {
        logic [1:0]  mask;
        logic [15:0] csr0, csr1;
        logic [31:0] a0, b0, a1, b1;
        int          re_dly;
        int          we_dly;
        logic [15:0] st;
        logic [31:0] c;
        int          hold;
        logic        exp_id;
        int          exp_lat;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        id;
        logic [15:0] csr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_resp_fields"}, {resp_id, resp_err, resp_csr, resp_data}, 64'd0);
        check({tag, "_csr_in"}, 64'(csr_in), 64'd0);
        check({tag, "_data_ab"}, {data_reg_a, data_reg_b}, 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        arst_n    = 1'b0;
        req_valid = 2'b11;
        #1;
        check_zero_outputs(tag);
        sb.delete();
        repeat (2) @(negedge clk);
        check_zero_outputs({tag, "_held"});
        arst_n     = 1'b1;
        req_valid  = '0;
        csr_in_re  = 1'b0;
        csr_out_we = 1'b0;
        resp_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t        e;
        logic [15:0] ecsr;
        logic [31:0] ea, eb;
        int          k;
        bit          got;
        @(negedge clk);
        req_valid  = v.mask;
        req_csr[0] = v.csr0; req_a[0] = v.a0; req_b[0] = v.b0;
        req_csr[1] = v.csr1; req_a[1] = v.a1; req_b[1] = v.b1;
        #1;
        check("req_ready_grant", 64'(req_ready), v.exp_id ? 64'd2 : 64'd1);
        ecsr   = v.exp_id ? v.csr1 : v.csr0;
        ea     = v.exp_id ? v.a1 : v.a0;
        eb     = v.exp_id ? v.b1 : v.b0;
        e.id   = v.exp_id;
        e.csr  = v.exp_err ? 16'h0 : v.st;
        e.data = v.exp_err ? 32'h0 : v.c;
        e.err  = v.exp_err;
        sb.push_back(e);
        got = 1'b0;
        for (k = 1; k <= 60; k++) begin
            @(negedge clk);
            req_valid  = '0;
            csr_in_re  = 1'b0;
            csr_out_we = 1'b0;
            #1;
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
            check("csr_in", 64'(csr_in), (k <= v.re_dly) ? 64'(ecsr) : 64'd0);
            check("data_reg_ab", {data_reg_a, data_reg_b}, {ea, eb});
            check("busy_active", 64'(busy), 64'd1);
            csr_in_re  = (k == v.re_dly);
            csr_out_we = (k == v.we_dly);
            csr_out    = (k == v.we_dly) ? v.st : 16'($urandom);
            data_reg_c = (k == v.we_dly) ? v.c : $urandom;
        end
        if (!got) begin
            check("resp_never_valid", 64'd0, 64'd1);
            sb.delete();
            return;
        end
        check("latency", 64'(k), 64'(v.exp_lat));
        // Spurious tile strobes and new requests while the response is held must change nothing.
        for (int h = 0; h < v.hold; h++) begin
            req_valid  = 2'b11;
            csr_out_we = 1'b1;
            csr_out    = 16'($urandom);
            data_reg_c = $urandom;
            @(negedge clk);
            #1;
            check("hold_resp_valid", 64'(resp_valid), 64'd1);
            check("hold_resp", {resp_id, resp_err, resp_csr, resp_data},
                  {sb[0].id, sb[0].err, sb[0].csr, sb[0].data});
            check("hold_req_ready", 64'(req_ready), 64'd0);
            check("hold_busy", 64'(busy), 64'd1);
        end
        req_valid  = 2'b11;
        csr_out_we = 1'b0;
        resp_ready = 1'b1;
        #1;
        check("resp_req_ready", 64'(req_ready), 64'd0);
        e = sb.pop_front();
        check("resp_id", 64'(resp_id), 64'(e.id));
        check("resp_csr", 64'(resp_csr), 64'(e.csr));
        check("resp_data", 64'(resp_data), 64'(e.data));
        check("resp_err", 64'(resp_err), 64'(e.err));
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = '0;
        #1;
        check("post_resp_idle", {62'd0, busy, resp_valid}, 64'd0);
    endtask

    vec_t vecs[8];
    vec_t tv;

    initial begin
        //          mask   csr0      csr1      a0    b0    a1    b1    re we st        c             hold id lat err
        vecs[0] = '{2'b11, 16'h0011, 16'h0021, 32'd1, 32'd2, 32'd3, 32'd4, 1, 2, 16'h8001, 32'h100,       0, 1'b0, 3, 1'b0};
        vecs[1] = '{2'b11, 16'h0012, 16'h0022, 32'd5, 32'd6, 32'd7, 32'd8, 1, 1, 16'h8003, 32'h200,       0, 1'b1, 2, 1'b0};
        vecs[2] = '{2'b11, 16'h0013, 16'h0023, 32'd9, 32'd10, 32'd11, 32'd12, 2, 4, 16'h8005, 32'h300,    0, 1'b0, 5, 1'b0};
        vecs[3] = '{2'b11, 16'h0014, 16'h0024, 32'd13, 32'd14, 32'd15, 32'd16, 1, 3, 16'h8007, 32'h400,   0, 1'b1, 4, 1'b0};
        vecs[4] = '{2'b01, 16'h0001, 16'h0000, 32'd5, 32'd7, 32'd0, 32'd0, 1, 3, 16'h8000, 32'd12,        0, 1'b0, 4, 1'b0};
        vecs[5] = '{2'b10, 16'h0000, 16'h0ABC, 32'd0, 32'd0, 32'h11, 32'h22, 1, 1, 16'h8002, 32'hDEADBEEF, 0, 1'b1, 2, 1'b0};
        vecs[6] = '{2'b01, 16'h0F0F, 16'h0000, 32'hA5A5, 32'h5A5A, 32'd0, 32'd0, 1, 2, 16'h4242, 32'hCAFE, 10, 1'b0, 3, 1'b0};
        vecs[7] = '{2'b11, 16'h0031, 16'h0032, 32'd21, 32'd22, 32'd23, 32'd24, 3, 3, 16'h1234, 32'h5678,  2, 1'b1, 4, 1'b0};

        req_valid = 2'b11;
        #2;
        check_zero_outputs("por");
        repeat (2) @(negedge clk);
        arst_n    = 1'b1;
        req_valid = '0;

        // A status strobe while idle must not leak into any response.
        @(negedge clk);
        csr_out_we = 1'b1;
        csr_out    = 16'hFFFF;
        data_reg_c = 32'hFFFFFFFF;
        @(negedge clk);
        csr_out_we = 1'b0;
        #1;
        check("idle_we_ignored", {62'd0, busy, resp_valid}, 64'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

`ifdef IP_TILE_ARB_TIMEOUT_EN
        tv = '{2'b01, 16'h0077, 16'h0, 32'd1, 32'd2, 32'd0, 32'd0, 1, 0, 16'h9999, 32'h9999, 1, 1'b0, TMO + 1, 1'b1};
        run_vec(tv);
`else
        @(negedge clk);
        req_valid  = 2'b01;
        req_csr[0] = 16'h0077;
        #1;
        check("tmo_off_accept", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = '0;
        csr_in_re = 1'b1;
        @(negedge clk);
        csr_in_re = 1'b0;
        for (int i = 0; i < 3 * TMO; i++) begin
            #1;
            check("tmo_off_busy", {62'd0, busy, resp_valid}, 64'd2);
            check("tmo_off_err", 64'(resp_err), 64'd0);
            @(negedge clk);
        end
        do_reset("tmo_off_rst");
`endif

        // Reset asserted while the tile holds the command in WAIT.
        @(negedge clk);
        req_valid  = 2'b01;
        req_csr[0] = 16'h0055;
        req_a[0]   = 32'h1111;
        req_b[0]   = 32'h2222;
        #1;
        check("rstwait_accept", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = '0;
        csr_in_re = 1'b1;
        @(negedge clk);
        csr_in_re = 1'b0;
        #1;
        check("rstwait_in_wait", {csr_in, 14'd0, busy, resp_valid}, 32'd2);
        arst_n = 1'b0;
        #1;
        check_zero_outputs("rstwait");
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            csr_out_we = 1'b1;
            @(negedge clk);
            #1;
            check("rstwait_no_resp", {62'd0, busy, resp_valid}, 64'd0);
        end
        csr_out_we = 1'b0;

        tv = '{2'b10, 16'h0, 16'h0066, 32'd0, 32'd0, 32'd77, 32'd88, 1, 2, 16'h8888, 32'h77, 0, 1'b1, 3, 1'b0};
        run_vec(tv);
        tv = '{2'b11, 16'h0101, 16'h0202, 32'd1, 32'd1, 32'd2, 32'd2, 1, 1, 16'h0303, 32'h404, 0, 1'b0, 2, 1'b0};
        run_vec(tv);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

endmodule
